// File: rtl/dmem_responder_pkg.sv
// dmem_responder shared constants and types.
// Default widths, wait-state limit and FSM encoding.
package dmem_responder_pkg;

  localparam int P_DSIZE      = 16;
  localparam int P_AWIDTH     = 16;
  localparam int P_DEPTH_LOG2 = 8;
  localparam int P_WAIT_MAX   = 15;
  localparam int P_CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // out-of-range wait parameters saturate into the counter range
  function automatic logic [P_CNT_W-1:0] wait_load(input int w);
    if (w > P_WAIT_MAX) return P_CNT_W'(P_WAIT_MAX);
    else if (w < 0) return '0;
    else return P_CNT_W'(w);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between MEM stage and data memory.
// master = MEM stage, slave = dmem_responder.
interface dmem_responder_if
  import dmem_responder_pkg::*;
#(
  parameter int DSIZE  = P_DSIZE,
  parameter int AWIDTH = P_AWIDTH
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AWIDTH-1:0] req_addr;
  logic [DSIZE-1:0]  req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DSIZE-1:0]  resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Word storage for dmem_responder.
// Sync write, comb read, sync active-low clear.
module dmem_array #(
  parameter int DSIZE      = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DSIZE-1:0]      i_wdata,
  output logic [DSIZE-1:0]      o_rdata
);

  localparam int LP_DEPTH = 1 << DEPTH_LOG2;

  logic [DSIZE-1:0] r_mem [LP_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LP_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states.
// One outstanding request; commit happens on RESP entry.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DSIZE      = P_DSIZE,
  parameter int AWIDTH     = P_AWIDTH,
  parameter int DEPTH_LOG2 = P_DEPTH_LOG2,
  parameter int WAIT       = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam logic [P_CNT_W-1:0] LP_WAIT = wait_load(WAIT);

  state_e r_state;
  state_e w_next;

  logic [P_CNT_W-1:0] r_cnt;
  logic               r_we;
  logic [AWIDTH-1:0]  r_addr;
  logic [DSIZE-1:0]   r_wdata;
  logic [DSIZE-1:0]   r_rdata;
  logic               r_err;

  logic              w_accept;
  logic              w_done;
  logic              w_enter_resp;
  logic              w_we;
  logic              w_err;
  logic              w_mem_we;
  logic [AWIDTH-1:0] w_addr;
  logic [DSIZE-1:0]  w_wdata;
  logic [DSIZE-1:0]  w_mem_rdata;

  assign w_accept = bus.req_valid && bus.req_ready;
  assign w_done   = (r_state == ST_RESP) && bus.resp_ready;

  // with zero wait states RESP is entered on the accept edge itself
  assign w_we    = (r_state == ST_IDLE) ? bus.req_we    : r_we;
  assign w_addr  = (r_state == ST_IDLE) ? bus.req_addr  : r_addr;
  assign w_wdata = (r_state == ST_IDLE) ? bus.req_wdata : r_wdata;

  assign w_err    = (w_addr >> DEPTH_LOG2) != '0;
  assign w_mem_we = w_enter_resp && w_we && !w_err;

  dmem_array #(
    .DSIZE     (DSIZE),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_mem_we),
    .i_addr (w_addr[DEPTH_LOG2-1:0]),
    .i_wdata(w_wdata),
    .o_rdata(w_mem_rdata)
  );

  always_comb begin
    w_next       = r_state;
    w_enter_resp = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (LP_WAIT == '0) begin
            w_next       = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == P_CNT_W'(1)) begin
          w_next       = ST_RESP;
          w_enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_cnt   <= LP_WAIT;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - P_CNT_W'(1);
      end
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_we || w_err) ? '0 : w_mem_rdata;
      end else if (w_done) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

  assign bus.req_ready  = rst && (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder.
// Instance a: WAIT=2, instance b: WAIT=0 back-to-back.
module tb_dmem_responder;

  localparam int WA = 2;
  localparam int WB = 0;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mode_a = 2;

  logic [15:0] mdl [2][256];
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if #(.DSIZE(16), .AWIDTH(16)) ia ();
  dmem_responder_if #(.DSIZE(16), .AWIDTH(16)) ib ();

  dmem_responder #(
    .DSIZE(16), .AWIDTH(16), .DEPTH_LOG2(8), .WAIT(WA)
  ) u_a (
    .clk(clk), .rst(rst_a), .bus(ia)
  );

  dmem_responder #(
    .DSIZE(16), .AWIDTH(16), .DEPTH_LOG2(8), .WAIT(WB)
  ) u_b (
    .clk(clk), .rst(rst_b), .bus(ib)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // reference: 256 words, anything at or above 256 is an error
  function automatic exp_t model_step(input int u, input logic we,
                                      input logic [15:0] a,
                                      input logic [15:0] d,
                                      input int ec);
    exp_t e;
    e.err     = (a >= 16'd256);
    e.exp_cyc = ec;
    e.rdata   = 16'h0;
    if (!e.err) begin
      if (we) mdl[u][a[7:0]] = d;
      else e.rdata = mdl[u][a[7:0]];
    end
    return e;
  endfunction

  task automatic clear_model(input int u);
    for (int i = 0; i < 256; i++) mdl[u][i] = 16'h0;
  endtask

  task automatic req_a(input logic we, input logic [15:0] a,
                       input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    ia.req_valid = 1'b1;
    ia.req_we    = we;
    ia.req_addr  = a;
    ia.req_wdata = d;
    while (!ia.req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("a_req_accept", 32'(ia.req_ready), 1);
    if (ia.req_ready) qa.push_back(model_step(0, we, a, d, cyc + WA + 1));
    @(posedge clk);
    #1 ia.req_valid = 1'b0;
  endtask

  task automatic req_b(input logic we, input logic [15:0] a,
                       input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    ib.req_valid = 1'b1;
    ib.req_we    = we;
    ib.req_addr  = a;
    ib.req_wdata = d;
    while (!ib.req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("b_req_accept", 32'(ib.req_ready), 1);
    if (ib.req_ready) qb.push_back(model_step(1, we, a, d, cyc + WB + 1));
    @(posedge clk);
    #1 ib.req_valid = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while ((qa.size() != 0 || ia.resp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("a_drain", 32'(qa.size()), 0);
  endtask

  task automatic drain_b();
    int n = 0;
    while ((qb.size() != 0 || ib.resp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("b_drain", 32'(qb.size()), 0);
  endtask

  task automatic chk_quiet_a(input string nm);
    chk({nm, "_req_ready"}, 32'(ia.req_ready), 0);
    chk({nm, "_resp_valid"}, 32'(ia.resp_valid), 0);
    chk({nm, "_rdata"}, 32'(ia.resp_rdata), 0);
    chk({nm, "_err"}, 32'(ia.resp_err), 0);
  endtask

  // resp_ready for a: 0 random, 1 held low, 2 held high
  initial begin
    ia.resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #3;
      if (mode_a == 2) ia.resp_ready = 1'b1;
      else if (mode_a == 1) ia.resp_ready = 1'b0;
      else ia.resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // monitor a
  initial begin
    logic first_a;
    logic done_a;
    first_a = 1'b1;
    done_a  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_a) begin
        first_a = 1'b1;
        done_a  = 1'b0;
      end else begin
        if (done_a) begin
          chk("a_idle_after_resp", 32'({ia.resp_valid, ia.req_ready}), 1);
          done_a = 1'b0;
        end
        if (ia.resp_valid) begin
          if (qa.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL a_unexpected_resp: got data 0x%0h, none expected",
                     ia.resp_rdata);
          end else begin
            if (first_a) chk("a_latency", cyc, qa[0].exp_cyc);
            chk("a_rdata", 32'(ia.resp_rdata), 32'(qa[0].rdata));
            chk("a_err", 32'(ia.resp_err), 32'(qa[0].err));
            chk("a_busy_ready", 32'(ia.req_ready), 0);
            if (ia.resp_ready) begin
              void'(qa.pop_front());
              first_a = 1'b1;
              done_a  = 1'b1;
            end else begin
              first_a = 1'b0;
            end
          end
        end else if (qa.size() != 0 && cyc > qa[0].exp_cyc) begin
          chk("a_late_resp", cyc, qa[0].exp_cyc);
          void'(qa.pop_front());
        end
      end
    end
  end

  // monitor b: resp_ready always high, responses every 2 cycles
  initial begin
    int last_b;
    logic have_last;
    have_last = 1'b0;
    last_b    = 0;
    forever begin
      @(negedge clk);
      if (rst_b && ib.resp_valid) begin
        if (qb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL b_unexpected_resp: got data 0x%0h, none expected",
                   ib.resp_rdata);
        end else begin
          chk("b_latency", cyc, qb[0].exp_cyc);
          chk("b_rdata", 32'(ib.resp_rdata), 32'(qb[0].rdata));
          chk("b_err", 32'(ib.resp_err), 32'(qb[0].err));
          if (have_last) chk("b_cadence", cyc - last_b, 2);
          last_b    = cyc;
          have_last = 1'b1;
          void'(qb.pop_front());
        end
      end else if (rst_b && qb.size() != 0 && cyc > qb[0].exp_cyc) begin
        chk("b_late_resp", cyc, qb[0].exp_cyc);
        void'(qb.pop_front());
      end
    end
  end

  task automatic seq_a();
    logic        we;
    logic [15:0] a;
    mode_a = 2;
    req_a(1'b0, 16'h0005, 16'h0);
    req_a(1'b1, 16'h0010, 16'hBEEF);
    req_a(1'b0, 16'h0010, 16'h0);
    drain_a();
    // stall: resp_ready held low well past response arrival
    mode_a = 1;
    req_a(1'b0, 16'h0010, 16'h0);
    repeat (WA + 6) @(negedge clk);
    chk("a_stall_valid", 32'(ia.resp_valid), 1);
    chk("a_stall_ready", 32'(ia.req_ready), 0);
    chk("a_stall_rdata", 32'(ia.resp_rdata), 32'hBEEF);
    mode_a = 2;
    drain_a();
    req_a(1'b1, 16'h0100, 16'h1234);
    req_a(1'b0, 16'h0000, 16'h0);
    drain_a();
    // reset while the store is still waiting
    req_a(1'b1, 16'h0020, 16'hCAFE);
    #1 rst_a = 1'b0;
    qa.delete();
    clear_model(0);
    @(negedge clk);
    chk_quiet_a("a_midrst");
    @(posedge clk);
    #2 rst_a = 1'b1;
    req_a(1'b0, 16'h0020, 16'h0);
    drain_a();
    mode_a = 0;
    repeat (80) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 16'($urandom);
      else a = 16'($urandom_range(0, 15));
      req_a(we, a, 16'($urandom));
    end
    mode_a = 2;
    drain_a();
  endtask

  task automatic seq_b();
    logic [15:0] a;
    req_b(1'b1, 16'h0001, 16'h1111);
    req_b(1'b1, 16'h0002, 16'h2222);
    req_b(1'b1, 16'h0003, 16'h3333);
    req_b(1'b0, 16'h0001, 16'h0);
    req_b(1'b0, 16'h0002, 16'h0);
    req_b(1'b0, 16'h0003, 16'h0);
    repeat (30) begin
      if ($urandom_range(0, 5) == 0) a = 16'h0100 | 16'($urandom_range(0, 7));
      else a = 16'($urandom_range(0, 7));
      req_b(1'($urandom_range(0, 1)), a, 16'($urandom));
    end
    drain_b();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ia.req_valid = 1'b0;
    ia.req_we    = 1'b0;
    ia.req_addr  = '0;
    ia.req_wdata = '0;
    ib.req_valid = 1'b0;
    ib.req_we    = 1'b0;
    ib.req_addr  = '0;
    ib.req_wdata = '0;
    ib.resp_ready = 1'b1;
    clear_model(0);
    clear_model(1);
    repeat (3) @(negedge clk);
    chk_quiet_a("a_rst");
    chk("b_rst_ready", 32'(ib.req_ready), 0);
    @(posedge clk);
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("a_rel_ready", 32'(ia.req_ready), 1);
    chk("a_rel_valid", 32'(ia.resp_valid), 0);
    chk("a_rel_rdata", 32'(ia.resp_rdata), 0);
    chk("b_rel_ready", 32'(ib.req_ready), 1);
    fork
      seq_a();
      seq_b();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined datapath: it answers the load/store requests issued by the MEM stage over a valid/ready request channel and a valid/ready response channel. Storage is an internal word-addressed array. A programmable wait-state counter models slow memory so the pipeline's stall path can be exercised. The block replaces the zero-latency D-memory model behind the same address/data widths.

## Interface
Parameters:
- DSIZE, 16, data word width (matches datapath `DSIZE`)
- AWIDTH, 16, request address width (matches datapath `ISIZE`)
- DEPTH_LOG2, 8, implemented words = 2^DEPTH_LOG2
- WAIT, 2, wait states between accept and response (0..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_we  in  1  1 = store, 0 = load
- req_addr  in  AWIDTH  word address
- req_wdata  in  DSIZE  store data
- resp_valid  out  1  response present
- resp_ready  in  1  datapath takes response
- resp_rdata  out  DSIZE  load data (0 for stores and errors)
- resp_err  out  1  address outside implemented range

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata, load counter with WAIT; next state WAIT if WAIT>0, else RESP.
- WAIT: req_ready=0; counter decrements each cycle; when counter==1 next state RESP.
- Entering RESP (same edge): range check on latched address; error = any bit above DEPTH_LOG2 set.
  - Store, no error: array[addr] <= wdata; resp_rdata <= 0.
  - Load, no error: resp_rdata <= array[addr].
  - Error: no write, resp_rdata <= 0, resp_err <= 1.
- RESP: resp_valid=1, req_ready=0; rdata/err held stable until resp_valid&&resp_ready, then IDLE, resp_valid=0, resp_err=0.
- One outstanding request; no request queueing, no response reordering.
- Stores return a response (acknowledge) like loads.

## Timing
- Reset (rst=0 at an edge): state IDLE, req_ready=0 while rst=0, resp_valid=0, resp_rdata=0, resp_err=0, counter=0, every array word cleared to 0. req_ready=1 from the first cycle after rst is released.
- Latency: accept edge at cycle N -> resp_valid first high in cycle N+WAIT+1.
- Throughput: at best one request per WAIT+2 cycles (RESP and IDLE not overlapped).
- resp_ready already high on the first RESP cycle: the response completes in that cycle. The next accept is possible one cycle later.
- resp_ready held low: the block stays in RESP indefinitely. Outputs do not change.
- Reset mid-operation (WAIT or RESP): the request is aborted. A store not yet committed is dropped. A store committed on RESP entry is lost through the array clear.
- Load issued right after a store to the same address: returns the new data, because the commit happens before the response.
- Address wrap: none. Out-of-range addresses are flagged, never aliased.

## Structure
- Shared package/defines: DSIZE, AWIDTH, the FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), and the WAIT range limit.
- Sub-module `dmem_array`: DEPTH words × DSIZE.
  - Synchronous write with enable.
  - Combinational read.
  - Synchronous active-low clear.
- FSM, counter, range check and output registers live in the top module.

## Test plan
- Reset with WAIT=2; rst released. Check: req_ready=1 the cycle after release; all outputs 0. Then load addr 0x0005 -> resp_rdata=0x0000, resp_err=0.
- Store 0xBEEF to 0x0010 accepted at cycle N, resp_ready=1. Check: resp_valid high only in cycle N+3, rdata=0; then load 0x0010 -> 0xBEEF.
- Load with resp_ready held 0 for 5 cycles. Check: resp_valid and rdata stay stable; req_ready=0 throughout; IDLE on the cycle after resp_ready=1.
- Store 0x1234 to 0x0100 (DEPTH_LOG2=8). Check: resp_err=1, rdata=0. Then load 0x0000 -> 0x0000, no aliasing.
- WAIT=0 build, back-to-back loads with resp_ready=1. Check: one response every 2 cycles, correct data for addresses 0x01, 0x02, 0x03.
- Store accepted, rst=0 during WAIT. Check: outputs clear on that edge; a later load of the same address -> 0x0000.
